// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU data-memory responder: RAM, IO registers and framebuffer write FIFO
// One-cycle registered reads; framebuffer stores queue in a small FIFO drained by a valid/ready sink.
module mem_responder #(
  parameter int    RAM_WORDS  = 1024,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [13:0] fb_addr,
  output logic [11:0] fb_data
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [25:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycles;

  logic          ram_sel;
  logic          io_sel;
  logic          fb_sel;
  logic          wr_en;
  logic [1:0]    io_reg;
  logic [AW-1:0] ram_idx;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          push_drop;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  assign ram_sel = (Address[31:12] == 20'h0);
  assign io_sel  = (Address[31:4] == 28'h0001000);
  assign fb_sel  = (Address[31:16] == 16'h0002);
  assign io_reg  = Address[3:2];
  assign ram_idx = Address[AW+1:2];
  assign wr_en   = MemWrite && !reset;
  assign unused_bits = ^Address;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign fb_valid  = !empty;
  assign pop       = fb_valid && fb_ready;
  assign push      = wr_en && fb_sel;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  assign fb_addr   = fifo_mem[rd_ptr][25:12];
  assign fb_data   = fifo_mem[rd_ptr][11:0];

  always_comb begin
    rdata_next = '0;
    if (ram_sel) begin
      rdata_next = ram[ram_idx];
    end else if (io_sel) begin
      case (io_reg)
        2'd0:    rdata_next = {24'b0, leds};
        2'd1:    rdata_next = cycles;
        2'd2:    rdata_next = {25'b0, overflow, 4'(count), empty, full};
        default: rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) begin
      ram[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {Address[15:2], WriteData[11:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData <= '0;
      leds     <= '0;
      cycles   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      ReadData <= rdata_next;
      if (wr_en && io_sel && io_reg == 2'd0) begin
        leds <= WriteData[7:0];
      end
      // Clearing zeroes the count in the write cycle itself, so it reads 1 one cycle later.
      if (wr_en && io_sel && io_reg == 2'd1) begin
        cycles <= 32'd1;
      end else begin
        cycles <= cycles + 32'd1;
      end
      if (wr_en && io_sel && io_reg == 2'd2) begin
        overflow <= 1'b0;
      end else if (push_drop) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vector table plus FIFO, counter and reset sequences for mem_responder
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic        fb_valid;
  logic        fb_ready = 1'b0;
  logic [13:0] fb_addr;
  logic [11:0] fb_data;

  int n_checks = 0;
  int n_fail = 0;

  mem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(ReadData), .leds(leds), .fb_valid(fb_valid),
    .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    Address = a;
    WriteData = d;
    MemWrite = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         8'h00};
    vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'h00};
    vecs[2]  = '{32'h0000_0014, 32'h1111_1111, 1'b1, 1'b0, 32'h0,         8'h00};
    vecs[3]  = '{32'h0000_0014, 32'h2222_2222, 1'b1, 1'b1, 32'h1111_1111, 8'h00};
    vecs[4]  = '{32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'h2222_2222, 8'h00};
    vecs[5]  = '{32'h0001_0000, 32'h0000_01A5, 1'b1, 1'b1, 32'h0,         8'hA5};
    vecs[6]  = '{32'h0001_0000, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, 8'hA5};
    vecs[7]  = '{32'h0001_000C, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         8'hA5};
    vecs[8]  = '{32'h0001_000C, 32'h0,         1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[9]  = '{32'h0003_0010, 32'h0BAD_F00D, 1'b1, 1'b1, 32'h0,         8'hA5};
    vecs[10] = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'hA5};
    vecs[11] = '{32'h0000_0410, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'hA5};
    vecs[12] = '{32'h0001_0000, 32'h0000_0033, 1'b0, 1'b1, 32'h0000_00A5, 8'hA5};
    vecs[13] = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'hA5};
    vecs[14] = '{32'h0000_0012, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'hA5};
    vecs[15] = '{32'h0002_0008, 32'h0000_0123, 1'b0, 1'b1, 32'h0,         8'hA5};
    vecs[16] = '{32'h0001_0008, 32'h0,         1'b0, 1'b1, 32'h0000_0002, 8'hA5};
    vecs[17] = '{32'h0001_0014, 32'h0,         1'b0, 1'b1, 32'h0,         8'hA5};

    @(posedge clk);
    #1;
    check("reset ReadData", ReadData, 32'h0);
    check("reset leds", {24'b0, leds}, 32'h0);
    check("reset fb_valid", {31'b0, fb_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      if (vecs[i].chk) check($sformatf("vec%0d ReadData", i), ReadData, vecs[i].exp_rd);
      check($sformatf("vec%0d leds", i), {24'b0, leds}, {24'b0, vecs[i].exp_leds});
    end

    // Cycle counter: clear, 9 idle cycles, then sample.
    cyc(32'h0001_0004, 32'h1234_5678, 1'b1);
    repeat (9) cyc(32'h0, 32'h0, 1'b0);
    cyc(32'h0001_0004, 32'h0, 1'b0);
    check("cycles after clear", ReadData, 32'd10);

    // Overflow: five stores with the sink stalled, fifth is lost.
    fb_ready = 1'b0;
    for (int k = 0; k < 5; k++) cyc(32'h0002_0008 + 32'(4 * k), 32'hFFFF_FA00 + 32'(k), 1'b1);
    check("ovf head valid", {31'b0, fb_valid}, 32'h1);
    check("ovf head addr", {18'b0, fb_addr}, 32'h2);
    cyc(32'h0001_0008, 32'h0, 1'b0);
    check("ovf fbstat", ReadData, 32'h51);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fb_ready = 1'b1;
      check($sformatf("drain%0d addr", k), {18'b0, fb_addr}, 32'(2 + k));
      check($sformatf("drain%0d data", k), {20'b0, fb_data}, 32'hA00 + 32'(k));
      check($sformatf("drain%0d valid", k), {31'b0, fb_valid}, 32'h1);
    end
    @(negedge clk);
    check("drained valid", {31'b0, fb_valid}, 32'h0);
    fb_ready = 1'b0;
    cyc(32'h0001_0008, 32'h0, 1'b0);
    check("sticky overflow", ReadData, 32'h42);
    cyc(32'h0001_0008, 32'h0, 1'b1);
    cyc(32'h0001_0008, 32'h0, 1'b0);
    check("overflow cleared", ReadData, 32'h02);

    // Full FIFO with a pop in the same cycle as a push.
    for (int k = 0; k < 4; k++) cyc(32'h0002_0020 + 32'(4 * k), 32'h0000_0B00 + 32'(k), 1'b1);
    cyc(32'h0001_0008, 32'h0, 1'b0);
    check("full fbstat", ReadData, 32'h11);
    @(negedge clk);
    fb_ready = 1'b1;
    Address = 32'h0002_0030;
    WriteData = 32'h0000_0B04;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    check("push+pop head", {18'b0, fb_addr}, 32'h9);
    @(negedge clk);
    fb_ready = 1'b0;
    MemWrite = 1'b0;
    Address = 32'h0001_0008;
    @(posedge clk);
    #1;
    check("push+pop fbstat", ReadData, 32'h11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fb_ready = 1'b1;
      check($sformatf("pp%0d addr", k), {18'b0, fb_addr}, 32'(9 + k));
      check($sformatf("pp%0d data", k), {20'b0, fb_data}, 32'hB01 + 32'(k));
    end
    @(negedge clk);
    check("pp drained", {31'b0, fb_valid}, 32'h0);
    fb_ready = 1'b0;

    // Asynchronous reset with pending entries.
    for (int k = 0; k < 3; k++) cyc(32'h0002_0040 + 32'(4 * k), 32'h0000_0C00, 1'b1);
    cyc(32'h0001_0000, 32'h0000_00FF, 1'b1);
    cyc(32'h0000_0010, 32'h0, 1'b0);
    check("pre-reset ReadData", ReadData, 32'hDEAD_BEEF);
    check("pre-reset leds", {24'b0, leds}, 32'hFF);
    check("pre-reset valid", {31'b0, fb_valid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async ReadData", ReadData, 32'h0);
    check("async leds", {24'b0, leds}, 32'h0);
    check("async fb_valid", {31'b0, fb_valid}, 32'h0);
    @(negedge clk);
    Address = 32'h0000_0010;
    WriteData = 32'h0;
    MemWrite = 1'b1;
    fb_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    MemWrite = 1'b0;
    fb_ready = 1'b0;
    cyc(32'h0000_0010, 32'h0, 1'b0);
    check("ram after reset", ReadData, 32'hDEAD_BEEF);
    cyc(32'h0001_0008, 32'h0, 1'b0);
    check("fbstat after reset", ReadData, 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
